// File: rtl/obi_mem_pkg.sv
// rtl/obi_mem_pkg.sv - shared types and constants for the OBI memory slave
//
// Contents:
//   OBI_DEF_DATA_W  default bus data width
//   OBI_NOP         default fill word (RISC-V NOP)
//   OBI_LFSR_SEED   stall LFSR reset value
//   OBI_LFSR_TAPS   stall LFSR feedback taps
//   obi_resp_t      response record {rdata, err} at the default width
//   lfsr_next()     one step of the stall LFSR
package obi_mem_pkg;

   localparam int          OBI_DEF_DATA_W = 32;
   localparam logic [31:0] OBI_NOP        = 32'h0000_0013;
   localparam logic [15:0] OBI_LFSR_SEED  = 16'hACE1;
   // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci LFSR: feedback from bits 0,2,3,5
   localparam logic [15:0] OBI_LFSR_TAPS  = 16'h002D;

   typedef struct packed {
      logic [OBI_DEF_DATA_W-1:0] rdata;
      logic                      err;
   } obi_resp_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & OBI_LFSR_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/obi_mem_resp_pipe.sv
// rtl/obi_mem_resp_pipe.sv - fixed-latency in-order response pipeline
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (clears all stages)
//   push_i         a response enters stage 0 at this edge
//   resp_i         response record to push
//   valid_o        last stage holds a response this cycle
//   resp_o         last stage response; holds its value while valid_o=0
module obi_mem_resp_pipe
   import obi_mem_pkg::*;
#(
   parameter int  LATENCY = 1,
   parameter type resp_t  = obi_resp_t
) (
   input  logic  clk,
   input  logic  reset_n,
   input  logic  push_i,
   input  resp_t resp_i,
   output logic  valid_o,
   output resp_t resp_o
);

   logic [LATENCY-1:0] valid_q, valid_d;
   resp_t              resp_q [LATENCY];
   resp_t              resp_d [LATENCY];

   // Data only moves along with a valid bit, so bubbles never overwrite the
   // last delivered response and the output stage holds between responses.
   always_comb begin
      valid_d    = '0;
      resp_d     = resp_q;
      valid_d[0] = push_i;
      if (push_i) resp_d[0] = resp_i;
      for (int i = 1; i < LATENCY; i++) begin
         valid_d[i] = valid_q[i-1];
         if (valid_q[i-1]) resp_d[i] = resp_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         for (int i = 0; i < LATENCY; i++) resp_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         resp_q  <= resp_d;
      end
   end

   assign valid_o = valid_q[LATENCY-1];
   assign resp_o  = resp_q[LATENCY-1];

endmodule

// File: rtl/obi_mem_slave.sv
// rtl/obi_mem_slave.sv - parametrised OBI memory slave with backdoor load port
//
// Optional feature: define OBI_MEM_STALL_EN to add LFSR-driven random grant stalls.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   req_i/we_i/be_i          OBI request, write enable, byte enables
//   addr_i/wdata_i           byte address (low bits ignored), write data
//   gnt_o                    grant (combinational)
//   rvalid_o/rdata_o/err_o   response; rdata_o/err_o hold while rvalid_o=0
//   bd_we_i/bd_addr_i/bd_wdata_i  backdoor full-word write, wins over a bus write
module obi_mem_slave
   import obi_mem_pkg::*;
#(
   parameter int                DATA_W          = 32,
   parameter int                DEPTH_WORDS     = 256,
   parameter int                LATENCY         = 1,
   parameter int                MAX_OUTSTANDING = 2,
   parameter logic [DATA_W-1:0] FILL_WORD       = DATA_W'(OBI_NOP)
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           req_i,
   input  logic                           we_i,
   input  logic [DATA_W/8-1:0]            be_i,
   input  logic [31:0]                    addr_i,
   input  logic [DATA_W-1:0]              wdata_i,
   output logic                           gnt_o,
   output logic                           rvalid_o,
   output logic [DATA_W-1:0]              rdata_o,
   output logic                           err_o,
   input  logic                           bd_we_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] bd_addr_i,
   input  logic [DATA_W-1:0]              bd_wdata_i
);

   localparam int               OFF_W   = $clog2(DATA_W/8);
   localparam int               IDX_W   = $clog2(DEPTH_WORDS);
   localparam int               CNT_W   = $clog2(MAX_OUTSTANDING+1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [31:0]      DEPTH_L = 32'(DEPTH_WORDS);

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } resp_t;

   // Contents start as FILL_WORD and are deliberately outside the reset domain.
   logic [DATA_W-1:0] mem_q [DEPTH_WORDS] = '{default: FILL_WORD};

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       word_idx;
   logic [IDX_W-1:0]  mem_idx;
   logic              in_range;
   logic              accept;
   logic              stall;
   logic              bus_wr;
   logic              bd_wr;
   logic [DATA_W-1:0] cur_word;
   logic [DATA_W-1:0] merged_word;
   resp_t             resp;
   logic              resp_valid;
   resp_t             resp_out;
   logic              unused_addr_bits;

   assign word_idx         = 32'(addr_i[31:OFF_W]);
   assign mem_idx          = word_idx[IDX_W-1:0];
   assign cur_word         = mem_q[mem_idx];
   assign unused_addr_bits = ^addr_i[OFF_W-1:0];

`ifdef OBI_MEM_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   assign lfsr_d = lfsr_next(lfsr_q);
   assign stall  = lfsr_q[0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) lfsr_q <= OBI_LFSR_SEED;
      else          lfsr_q <= lfsr_d;
   end
`else
   assign stall = 1'b0;
`endif

   always_comb begin
      // A slot freed by this cycle's response can be reused in the same cycle.
      gnt_o    = reset_n && req_i && !stall && ((cnt_q < MAX_CNT) || resp_valid);
      accept   = gnt_o;
      in_range = word_idx < DEPTH_L;
      bus_wr   = accept && we_i && in_range;
      bd_wr    = bd_we_i && reset_n;

      merged_word = cur_word;
      for (int b = 0; b < DATA_W/8; b++) begin
         if (be_i[b]) merged_word[b*8 +: 8] = wdata_i[b*8 +: 8];
      end

      resp     = '0;
      resp.err = !in_range;
      if (!we_i) resp.rdata = in_range ? cur_word : FILL_WORD;

      cnt_d = cnt_q;
      case ({accept, resp_valid})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Backdoor assignment comes second so it wins a same-word collision.
   always_ff @(posedge clk) begin
      if (bus_wr) mem_q[mem_idx]   <= merged_word;
      if (bd_wr)  mem_q[bd_addr_i] <= bd_wdata_i;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   obi_mem_resp_pipe #(
      .LATENCY (LATENCY),
      .resp_t  (resp_t)
   ) u_resp_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (accept),
      .resp_i  (resp),
      .valid_o (resp_valid),
      .resp_o  (resp_out)
   );

   assign rvalid_o = resp_valid;
   assign rdata_o  = resp_out.rdata;
   assign err_o    = resp_out.err;

endmodule

// File: doc/obi_mem_slave.md
# obi_mem_slave

Parametrised OBI memory slave used as instruction and/or data memory in the RISC-V testbench. It replaces the single-outstanding, fixed-1-latency instruction memory model. It adds configurable width, depth and latency, multiple outstanding transactions, byte-enabled writes, error responses and a clocked backdoor load port. It sits between the core's OBI master port and the testbench program loader.

## Interface
- DATA_W, 32, data width in bits (multiple of 8)
- DEPTH_WORDS, 256, memory depth in DATA_W words
- LATENCY, 1, cycles from acceptance to rvalid (≥1)
- MAX_OUTSTANDING, 2, accepted-but-unanswered transaction limit (≥1)
- FILL_WORD, 32'h0000_0013, initial contents and out-of-range read data (NOP)
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_i  in  1  OBI request
- we_i  in  1  write enable (0 = read)
- be_i  in  DATA_W/8  byte enables
- addr_i  in  32  byte address; word index = addr_i[31:$clog2(DATA_W/8)], low bits ignored
- wdata_i  in  DATA_W  write data
- gnt_o  out  1  grant
- rvalid_o  out  1  response valid
- rdata_o  out  DATA_W  read data
- err_o  out  1  error, qualified by rvalid_o
- bd_we_i  in  1  backdoor write strobe
- bd_addr_i  in  $clog2(DEPTH_WORDS)  backdoor word index
- bd_wdata_i  in  DATA_W  backdoor full-word data

## Operation
- Acceptance: req_i && gnt_o in the same cycle. gnt_o = req_i && (cnt < MAX_OUTSTANDING), combinational.
- cnt is `$clog2(MAX_OUTSTANDING+1)` bits wide:
  - +1 on acceptance, −1 on rvalid_o.
  - Unchanged when both happen in one cycle.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- Read: the memory word is sampled at the accepting edge and pushed into the response pipeline.
- Write:
  - Bytes with be_i=1 are updated at the accepting edge.
  - The response carries rdata_o=0, err_o=0.
  - be_i=0 is a legal no-op write that still gets a response.
- Out of range (word index ≥ DEPTH_WORDS):
  - No memory access.
  - Response has err_o=1; rdata_o=FILL_WORD for reads and 0 for writes.
- Responses are strictly in acceptance order, one per accepted request.
- Backdoor:
  - bd_we_i writes bd_wdata_i to bd_addr_i at the rising edge.
  - If it collides with a bus write to the same word, the backdoor wins.
  - A bus read of the same word in that cycle returns the old data (read-before-write).
  - The backdoor has no response and does not touch cnt.
- Memory contents are FILL_WORD at time zero and are not affected by reset.

## Timing
- Transaction accepted in cycle t → rvalid_o high for exactly one cycle in cycle t+LATENCY, with rdata_o/err_o valid in that cycle.
- Back-to-back acceptance is allowed every cycle while cnt permits. The per-cycle limit is MAX_OUTSTANDING ≥ LATENCY.
- With MAX_OUTSTANDING < LATENCY, gnt_o stays low until the oldest response retires. In the retire cycle a new request may be granted.
- rdata_o/err_o hold their last values when rvalid_o=0.
- Reset values:
  - gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0.
  - cnt=0 and the pipeline is empty.
- Reset asserted mid-transaction:
  - All in-flight responses are dropped.
  - Writes already accepted remain in memory.
- Backdoor writes are ignored while reset_n=0.

## Configuration
- OBI_MEM_STALL_EN defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every cycle.
  - gnt_o is additionally forced low when LFSR[0]=1.
  - Requests must remain stable until granted, as OBI requires.
- Not defined: no LFSR; gnt_o depends only on req_i and cnt.

## Structure
- Package obi_mem_pkg:
  - obi_resp_t struct {rdata, err}.
  - Default NOP constant 32'h0000_0013.
  - LFSR seed and tap constants.
- Sub-module obi_mem_resp_pipe:
  - LATENCY-stage valid + obi_resp_t shift register.
  - Asynchronous clear on reset_n.
  - Output stage drives rvalid_o/rdata_o/err_o.

## Test plan
- Preload via backdoor word 4 = 32'hDEAD_BEEF, LATENCY=1; read addr 0x10 → gnt same cycle; next cycle rvalid_o=1, rdata_o=32'hDEAD_BEEF, err_o=0.
- LATENCY=3, MAX_OUTSTANDING=2, reads to 0x0/0x4/0x8 issued back-to-back:
  - Third request is held with gnt_o=0 until the first rvalid_o cycle.
  - Responses arrive in order.
- Write 32'h1122_3344 to 0x20 with be_i=4'b0101, word previously FILL_WORD → readback 32'h0022_0044 | (FILL_WORD & 32'hFF00_FF00) = 32'h0022_0044.
- Read 0x400 with DEPTH_WORDS=256 → rvalid_o=1, err_o=1, rdata_o=32'h0000_0013. Write to 0x400 → err_o=1 and memory unchanged.
- Same cycle: bus write 32'hAAAA_AAAA and backdoor write 32'h5555_5555 to word 2 → later read returns 32'h5555_5555.
- Assert reset_n=0 with 2 reads in flight → no rvalid_o; all outputs 0. After release, cnt=0 and a new read completes normally.
